// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider: channel-select width
// and the per-channel default half-period.
package clk_div_pkg;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default H = 2^i keeps channels 0..2 on the legacy /2, /4, /8 ratios;
    // larger indices saturate to the widest half-period the counter holds.
    function automatic int unsigned def_half(input int i, input int cnt_w);
        int unsigned sat;
        int unsigned pow;
        sat = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        if (i >= 32) begin
            return sat;
        end
        pow = 32'd1 << i;
        return (pow > sat) ? sat : pow;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, registered clock/tick outputs,
// and a shadow register that is applied only at rising period boundaries.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int CH_IDX = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             out_o,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(def_half(CH_IDX, CNT_W));

    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    always_comb begin
        half_d   = half_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        tick_d   = 1'b0;

        if (sync_i) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (we_i) begin
                half_d   = half_i;
                shadow_d = half_i;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                half_d = shadow_q;
                pend_d = 1'b0;
            end
        end else if (half_q == '0) begin
            // Stopped: nothing to protect, so new values take effect at once.
            cnt_d = '0;
            out_d = 1'b0;
            if (we_i) begin
                half_d   = half_i;
                shadow_d = half_i;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                half_d = shadow_q;
                pend_d = 1'b0;
            end
        end else begin
            if (cnt_q == half_q - CNT_W'(1)) begin
                cnt_d = '0;
                if (out_q) begin
                    out_d = 1'b0;
                end else begin
                    if (pend_q) begin
                        half_d = shadow_q;
                        pend_d = 1'b0;
                    end
                    // A pending stop suppresses the rise instead of making a runt.
                    if (half_d != '0) begin
                        out_d  = 1'b1;
                        tick_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (we_i) begin
                shadow_d = half_i;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            half_q   <= DEF_HALF;
            shadow_q <= DEF_HALF;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            half_q   <= half_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign out_o  = out_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: decodes config writes to the
// addressed channel and gathers the per-channel outputs.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int  N_CH  = 3,
    parameter int  CNT_W = 8,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  cfg_pending,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] ch_we;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no entry and are dropped here.
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W  (CNT_W),
            .CH_IDX (i)
        ) u_chan (
            .clk_i   (CLK),
            .rst_n_i (reset),
            .sync_i  (sync),
            .we_i    (ch_we[i]),
            .half_i  (cfg_half),
            .out_o   (clk_out[i]),
            .tick_o  (tick[i]),
            .pend_o  (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a stimulus table plus a few
// hand-written sequences, checked against a period-schedule model.
module tb_clk_div_prog;

    localparam int N_CH  = 3;
    localparam int CNT_W = 8;

    logic             CLK;
    logic             reset;
    logic             sync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic [N_CH-1:0]  cfg_pending;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    clk_div_prog #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_half    (cfg_half),
        .cfg_pending (cfg_pending),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [N_CH-1:0] clk;
        logic [N_CH-1:0] tck;
        logic [N_CH-1:0] pend;
    } exp_t;

    typedef struct {
        logic            rst;
        logic            syn;
        logic            we;
        logic [1:0]      ch;
        logic [7:0]      half;
        int              n;
        logic [N_CH-1:0] exp_pend;
        logic [N_CH-1:0] pmask;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[20];

    int check_cnt = 0;
    int err_cnt   = 0;
    int cyc       = 0;

    // Model: each running channel follows rises at base+H, base+3H, ...
    int h_m[N_CH];
    int sh_m[N_CH];
    int base_m[N_CH];
    bit pend_m[N_CH];

    function automatic int def_h(input int i);
        int v;
        v = 1 << i;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic w,
                              input logic [1:0] ch, input logic [7:0] hv);
        cyc++;
        for (int i = 0; i < N_CH; i++) begin
            logic wr;
            wr = w && (int'(ch) == i);
            if (!r) begin
                h_m[i] = def_h(i); sh_m[i] = def_h(i); pend_m[i] = 0; base_m[i] = cyc;
            end else if (s) begin
                base_m[i] = cyc;
                if (wr) begin
                    h_m[i] = int'(hv); sh_m[i] = int'(hv); pend_m[i] = 0;
                end else if (pend_m[i]) begin
                    h_m[i] = sh_m[i]; pend_m[i] = 0;
                end
            end else if (h_m[i] == 0) begin
                base_m[i] = cyc;
                if (wr) begin
                    h_m[i] = int'(hv); sh_m[i] = int'(hv);
                end
            end else begin
                if ((((cyc - base_m[i]) % (2 * h_m[i])) == h_m[i]) && pend_m[i]) begin
                    pend_m[i] = 0;
                    if (sh_m[i] == 0) begin
                        h_m[i] = 0;
                    end else begin
                        h_m[i]    = sh_m[i];
                        base_m[i] = cyc - h_m[i];
                    end
                end
                if (wr) begin
                    sh_m[i] = int'(hv); pend_m[i] = 1;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int k;
        e = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (h_m[i] != 0) begin
                k = cyc - base_m[i];
                e.clk[i] = ((k / h_m[i]) % 2) == 1;
                e.tck[i] = (k % (2 * h_m[i])) == h_m[i];
            end
            e.pend[i] = pend_m[i];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [N_CH-1:0] act, input logic [N_CH-1:0] expv);
        check_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", nm, cyc, act, expv);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int expv);
        check_cnt++;
        if (act != expv) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic w,
                        input logic [1:0] ch, input logic [7:0] hv);
        exp_t e;
        reset    = r;
        sync     = s;
        cfg_we   = w;
        cfg_ch   = ch;
        cfg_half = hv;
        model_edge(r, s, w, ch, hv);
        sb_q.push_back(model_out());
        @(posedge CLK);
        @(negedge CLK);
        if (sb_q.size() == 0) begin
            chk_int("scoreboard_underflow", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("clk_out", clk_out, e.clk);
            chk("tick", tick, e.tck);
            chk("cfg_pending", cfg_pending, e.pend);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        int  t0, t1, t2, w_at, nticks;
        bit  found;

        reset = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_half = 8'd0;

        //        rst   sync  we    ch    half  n   pend    mask
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3,  3'b000, 3'b111};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 15, 3'b000, 3'b111};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd5, 1,  3'b010, 3'b111};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 30, 3'b000, 3'b111};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd3, 1,  3'b001, 3'b111};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd7, 1,  3'b001, 3'b111};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 40, 3'b000, 3'b111};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 8'd0, 1,  3'b100, 3'b111};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 30, 3'b000, 3'b111};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd2, 8'd4, 1,  3'b000, 3'b111};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 20, 3'b000, 3'b111};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd3, 1,  3'b001, 3'b001};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd5, 1,  3'b010, 3'b010};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd6, 1,  3'b000, 3'b111};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 14, 3'b000, 3'b111};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd2, 1,  3'b001, 3'b001};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'd9, 1,  3'b010, 3'b010};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 2,  3'b000, 3'b111};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'd50, 1, 3'b000, 3'b111};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 20, 3'b000, 3'b111};

        for (int v = 0; v < 20; v++) begin
            step(tbl[v].rst, tbl[v].syn, tbl[v].we, tbl[v].ch, tbl[v].half);
            for (int k = 1; k < tbl[v].n; k++) begin
                step(tbl[v].rst, 1'b0, 1'b0, 2'd0, 8'd0);
            end
            chk($sformatf("vec%0d_pend", v), cfg_pending & tbl[v].pmask,
                tbl[v].exp_pend & tbl[v].pmask);
        end

        // Channel 1 (H=2) reprogrammed to 5 just after a rise: 4 then 10 cycles.
        found = 0; t0 = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            idle();
            if (tick[1]) begin found = 1; t0 = cyc; end
        end
        chk_int("seqA_first_tick_seen", int'(found), 1);
        step(1'b1, 1'b0, 1'b1, 2'd1, 8'd5);
        chk_int("seqA_pending_set", int'(cfg_pending[1]), 1);
        found = 0; t1 = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            idle();
            if (tick[1]) begin found = 1; t1 = cyc; end
        end
        chk_int("seqA_old_period", t1 - t0, 4);
        chk_int("seqA_pending_cleared", int'(cfg_pending[1]), 0);
        found = 0; t2 = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            idle();
            if (tick[1]) begin found = 1; t2 = cyc; end
        end
        chk_int("seqA_new_period", t2 - t1, 10);

        // Stop channel 0, confirm silence, then restart with H=4.
        step(1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
        nticks = 0;
        for (int n = 0; n < 30; n++) begin
            idle();
            if (tick[0]) nticks++;
        end
        chk_int("seqB_ticks_after_stop", nticks, 0);
        chk_int("seqB_stopped_low", int'(clk_out[0]), 0);
        step(1'b1, 1'b0, 1'b1, 2'd0, 8'd4);
        w_at = cyc; found = 0; t0 = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            idle();
            if (clk_out[0]) begin found = 1; t0 = cyc; end
        end
        chk_int("seqB_restart_latency", t0 - w_at, 4);

        chk_int("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock divider. Generalised successor of the fixed /2, /4, /8 divider.
- Fully synchronous single clock domain: every channel output is a register clocked by CLK, with no ripple clocks.
- Per-channel half-period is runtime programmable. New values take effect glitch-free at period boundaries.
- A global sync input phase-aligns all channels. Sits between the system clock input and the downstream serializer and timing logic.

Parameters:
- N_CH, 3, number of divider channels (1..16).
- CNT_W, 8, width of half-period value and internal counter.
- Local CH_W = max(1, clog2(N_CH)), width of the channel select.

Ports:
- CLK  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- sync  in  1  one-cycle pulse; restarts all channels in phase.
- cfg_we  in  1  write strobe for half-period shadow register.
- cfg_ch  in  CH_W  channel selected by cfg_we.
- cfg_half  in  CNT_W  new half-period H in CLK cycles; 0 = channel stopped.
- cfg_pending  out  N_CH  bit i = shadow value for channel i not yet applied.
- clk_out  out  N_CH  divided clock per channel, period 2*H CLK cycles, 50% duty.
- tick  out  N_CH  one-cycle pulse in the first cycle clk_out[i] is high.

Behaviour:
- Per channel i, registers:
  - half (active H)
  - shadow
  - pend
  - cnt (CNT_W)
  - out
  - tick
- Reset (reset=0 at posedge), highest priority:
  - cnt=0, out=0, tick=0, pend=0.
  - half = shadow = DEF_HALF(i) = 2^i, saturated to 2^CNT_W-1. This reproduces the legacy /2, /4, /8 ratios for i = 0, 1, 2.
  - All outputs 0 during reset.
- Running (half != 0), each posedge:
  - If cnt == half-1: cnt<=0, out<=~out. Otherwise cnt<=cnt+1.
  - tick <= 1 only in the cycle where out goes 0->1; otherwise tick <= 0.
- Latency: with H set, after reset release (or sync) the first rising clk_out occurs on the H-th posedge. Thereafter clk_out toggles every H cycles.
  - H=1 gives clk_out toggling every cycle (CLK/2).
- Period boundary: the posedge where out toggles 0->1.
  - If pend=1 at that edge: half<=shadow, pend<=0, and the cnt reload uses the new half from that edge.
  - Result: no runt or stretched high phase is ever produced.
- Config write (cfg_we=1, cfg_ch<N_CH): shadow[cfg_ch]<=cfg_half, pend<=1.
  - cfg_ch >= N_CH: write ignored, no state change.
  - Repeated writes before the boundary: last value wins.
  - Write equal to the current half still sets pend; harmless.
- Stopped channel (half==0): out=0, cnt=0, tick=0.
  - A write to a stopped channel applies immediately on the next edge: half<=cfg_half, pend stays 0, cnt=0, out=0.
  - Counting starts from that edge.
- Stopping: a write of 0 to a running channel takes effect at the next boundary. At that edge out is forced to 0 (no rise, no tick), then the channel is held stopped.
- sync=1 (below reset, above boundary logic), all channels:
  - cnt<=0, out<=0, tick<=0.
  - Every pending shadow is applied (half<=shadow, pend<=0).
- Simultaneous sync and cfg_we: the written value goes straight to half, pend=0.
- Simultaneous cfg_we and boundary on the same channel: the old shadow is applied at the boundary; the new write becomes the shadow with pend=1.
- Reset mid-operation discards all pending values and returns to defaults.
- cfg_pending = pend vector, registered.

Decomposition:
- Package clk_div_pkg holds:
  - function def_half(i, CNT_W), including saturation.
  - CH_W computation.
- Sub-module clk_div_chan (one per channel, generate loop) contains the counter, out/tick registers, shadow/pend logic, and sync/apply inputs.
- Top level contains only address decode of cfg_we/cfg_ch and port concatenation.

Test Plan:
- Reset, then release with defaults, N_CH=3 -> clk_out[0] period 2, [1] period 4, [2] period 8. First rises at edges 1, 2, 4 after release. Exactly one tick per rising edge.
- Channel 1 running H=2; write cfg_half=5 mid high phase -> cfg_pending[1]=1. Current period completes at 4 cycles; next period is 10 cycles (5 high / 5 low); pend clears at that boundary edge.
- Write ch0 H=3 then H=7 before the boundary -> only H=7 applied. No period of 6 observed after the boundary.
- Write H=0 to ch2 -> clk_out[2] low from the next boundary with no further ticks. Write H=4 -> first rise 4 edges after the write edge.
- Channels set to H=3, 5, 6, pulse sync -> all outputs low the next cycle, rises at edges 3, 5, 6 after sync. Pending values are applied at the sync edge.
- Assert reset mid-period with pending writes -> all outputs and cfg_pending 0. After release, default ratios resume; cfg_ch=3 (out of range) write has no effect.
